// File: rtl/memory_stage_if.sv
// Execute-side, data-memory and writeback signals for the memory stage.
// Vectors are big-endian numbered: bit 0 is the MSB.
interface memory_stage_if;
   logic        in_valid;
   logic        in_load;
   logic        in_store;
   logic        in_byte;
   logic        in_ubyte;
   logic        in_rwe;
   logic [0:4]  in_rd;
   logic [0:31] in_alu_out;
   logic [0:31] in_store_data;
   logic        in_ready;

   logic [0:31] mem_addr;
   logic [0:31] mem_wdata;
   logic        mem_enable;
   logic        mem_wren;
   logic        mem_byte_only;
   logic [0:1]  mem_acc_size;
   logic [0:31] mem_rdata;
   logic        mem_busy;

   logic        out_valid;
   logic        out_rwe;
   logic [0:4]  out_rd;
   logic [0:31] out_data;
   logic        err_misalign;
   logic        err_timeout;

   modport slave (
      input  in_valid, in_load, in_store, in_byte, in_ubyte, in_rwe, in_rd,
             in_alu_out, in_store_data, mem_rdata, mem_busy,
      output in_ready, mem_addr, mem_wdata, mem_enable, mem_wren, mem_byte_only,
             mem_acc_size, out_valid, out_rwe, out_rd, out_data,
             err_misalign, err_timeout
   );

   modport master (
      output in_valid, in_load, in_store, in_byte, in_ubyte, in_rwe, in_rd,
             in_alu_out, in_store_data, mem_rdata, mem_busy,
      input  in_ready, mem_addr, mem_wdata, mem_enable, mem_wren, mem_byte_only,
             mem_acc_size, out_valid, out_rwe, out_rd, out_data,
             err_misalign, err_timeout
   );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: passes ALU results through, performs word/byte
// loads and stores against a busy-capable data memory with a bounded wait.
module memory_stage #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic           clock,
   input  logic           reset_n,
   memory_stage_if.slave  bus
);
   localparam int unsigned WAIT_W = 4;

   typedef enum logic {S_IDLE, S_ACCESS} state_t;

   state_t              state_q,   state_d;
   logic [0:31]         addr_q,    addr_d;
   logic [0:31]         wdata_q,   wdata_d;
   logic                store_q,   store_d;
   logic                byte_q,    byte_d;
   logic                ubyte_q,   ubyte_d;
   logic                rwe_q,     rwe_d;
   logic [0:4]          rd_q,      rd_d;
   logic [WAIT_W-1:0]   wait_q,    wait_d;
   logic                ovalid_q,  ovalid_d;
   logic                orwe_q,    orwe_d;
   logic [0:4]          ord_q,     ord_d;
   logic [0:31]         odata_q,   odata_d;
   logic                emis_q,    emis_d;
   logic                eto_q,     eto_d;

   logic [0:7]          lane_byte;
   logic [0:31]         load_fmt;

   // Big-endian lane pick for byte loads, then sign or zero extension.
   always_comb begin
      lane_byte = bus.mem_rdata[0:7];
      case (addr_q[30:31])
         2'd1:    lane_byte = bus.mem_rdata[8:15];
         2'd2:    lane_byte = bus.mem_rdata[16:23];
         2'd3:    lane_byte = bus.mem_rdata[24:31];
         default: lane_byte = bus.mem_rdata[0:7];
      endcase
      if (byte_q) load_fmt = {{24{lane_byte[0] & ~ubyte_q}}, lane_byte};
      else        load_fmt = bus.mem_rdata;
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      store_d  = store_q;
      byte_d   = byte_q;
      ubyte_d  = ubyte_q;
      rwe_d    = rwe_q;
      rd_d     = rd_q;
      wait_d   = wait_q;
      ovalid_d = 1'b0;
      orwe_d   = orwe_q;
      ord_d    = ord_q;
      odata_d  = odata_q;
      emis_d   = emis_q;
      eto_d    = eto_q;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               if (bus.in_load || bus.in_store) begin
                  if (!bus.in_byte && (bus.in_alu_out[30:31] != 2'b00)) begin
                     emis_d   = 1'b1;
                     ovalid_d = 1'b1;
                     orwe_d   = 1'b0;
                  end else begin
                     state_d = S_ACCESS;
                     addr_d  = bus.in_alu_out;
                     wdata_d = bus.in_byte ? {4{bus.in_store_data[24:31]}}
                                           : bus.in_store_data;
                     store_d = bus.in_store;
                     byte_d  = bus.in_byte;
                     ubyte_d = bus.in_ubyte;
                     rwe_d   = bus.in_rwe;
                     rd_d    = bus.in_rd;
                     wait_d  = '0;
                  end
               end else begin
                  ovalid_d = 1'b1;
                  odata_d  = bus.in_alu_out;
                  orwe_d   = bus.in_rwe;
                  ord_d    = bus.in_rd;
               end
            end
         end
         S_ACCESS: begin
            if (!bus.mem_busy) begin
               state_d  = S_IDLE;
               ovalid_d = 1'b1;
               ord_d    = rd_q;
               if (store_q) begin
                  orwe_d = 1'b0;
               end else begin
                  orwe_d  = rwe_q;
                  odata_d = load_fmt;
               end
            end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
               state_d  = S_IDLE;
               eto_d    = 1'b1;
               ovalid_d = 1'b1;
               orwe_d   = 1'b0;
            end else begin
               wait_d = WAIT_W'(wait_q + WAIT_W'(1));
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         store_q  <= 1'b0;
         byte_q   <= 1'b0;
         ubyte_q  <= 1'b0;
         rwe_q    <= 1'b0;
         rd_q     <= '0;
         wait_q   <= '0;
         ovalid_q <= 1'b0;
         orwe_q   <= 1'b0;
         ord_q    <= '0;
         odata_q  <= '0;
         emis_q   <= 1'b0;
         eto_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         store_q  <= store_d;
         byte_q   <= byte_d;
         ubyte_q  <= ubyte_d;
         rwe_q    <= rwe_d;
         rd_q     <= rd_d;
         wait_q   <= wait_d;
         ovalid_q <= ovalid_d;
         orwe_q   <= orwe_d;
         ord_q    <= ord_d;
         odata_q  <= odata_d;
         emis_q   <= emis_d;
         eto_q    <= eto_d;
      end
   end

   // Memory request is a pure decode of the state and latched request.
   assign bus.in_ready      = (state_q == S_IDLE);
   assign bus.mem_enable    = (state_q == S_ACCESS);
   assign bus.mem_wren      = (state_q == S_ACCESS) && store_q;
   assign bus.mem_byte_only = (state_q == S_ACCESS) && byte_q;
   assign bus.mem_acc_size  = 2'b00;
   assign bus.mem_addr      = addr_q;
   assign bus.mem_wdata     = wdata_q;
   assign bus.out_valid     = ovalid_q;
   assign bus.out_rwe       = orwe_q;
   assign bus.out_rd        = ord_q;
   assign bus.out_data      = odata_q;
   assign bus.err_misalign  = emis_q;
   assign bus.err_timeout   = eto_q;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: pass-through, loads, stores, wait/timeout,
// misalignment and asynchronous reset in the middle of an access.
module tb_memory_stage;
   localparam int unsigned MAX_WAIT = 15;

   logic clock;
   logic reset_n;
   int   vectors;
   int   miscompares;

   memory_stage_if bus();

   memory_stage #(.MAX_WAIT(MAX_WAIT)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_valid      = 1'b0;
      bus.in_load       = 1'b0;
      bus.in_store      = 1'b0;
      bus.in_byte       = 1'b0;
      bus.in_ubyte      = 1'b0;
      bus.in_rwe        = 1'b0;
      bus.in_rd         = '0;
      bus.in_alu_out    = '0;
      bus.in_store_data = '0;
   endtask

   task automatic issue_load(input logic [31:0] addr, input logic [4:0] rd,
                             input logic is_byte, input logic is_ubyte);
      idle_inputs();
      bus.in_valid   = 1'b1;
      bus.in_load    = 1'b1;
      bus.in_byte    = is_byte;
      bus.in_ubyte   = is_ubyte;
      bus.in_rwe     = 1'b1;
      bus.in_rd      = rd;
      bus.in_alu_out = addr;
   endtask

   initial begin
      clock         = 1'b0;
      reset_n       = 1'b0;
      vectors       = 0;
      miscompares   = 0;
      bus.mem_rdata = '0;
      bus.mem_busy  = 1'b0;
      idle_inputs();

      #12;
      chk("rst_in_ready",   32'(bus.in_ready),   32'd1);
      chk("rst_out_valid",  32'(bus.out_valid),  32'd0);
      chk("rst_mem_enable", 32'(bus.mem_enable), 32'd0);
      chk("rst_out_data",   bus.out_data,        32'h0);
      chk("rst_out_rd",     32'(bus.out_rd),     32'd0);
      chk("rst_errs",       32'({bus.err_misalign, bus.err_timeout}), 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;

      // ALU pass-through
      bus.in_valid = 1'b1; bus.in_alu_out = 32'h0000_002A; bus.in_rd = 5'd5; bus.in_rwe = 1'b1;
      cyc();
      chk("alu_valid",  32'(bus.out_valid),  32'd1);
      chk("alu_data",   bus.out_data,        32'h0000_002A);
      chk("alu_rd",     32'(bus.out_rd),     32'd5);
      chk("alu_rwe",    32'(bus.out_rwe),    32'd1);
      chk("alu_memen",  32'(bus.mem_enable), 32'd0);
      idle_inputs();
      cyc();
      chk("alu_pulse",  32'(bus.out_valid),  32'd0);
      chk("alu_hold",   bus.out_data,        32'h0000_002A);

      // word load, no wait
      issue_load(32'h8002_0010, 5'd7, 1'b0, 1'b0);
      bus.mem_rdata = 32'h1234_5678;
      cyc();
      idle_inputs();
      chk("wl_ready",   32'(bus.in_ready),     32'd0);
      chk("wl_memen",   32'(bus.mem_enable),   32'd1);
      chk("wl_addr",    bus.mem_addr,          32'h8002_0010);
      chk("wl_wren",    32'(bus.mem_wren),     32'd0);
      chk("wl_size",    32'(bus.mem_acc_size), 32'd0);
      chk("wl_nvalid",  32'(bus.out_valid),    32'd0);
      cyc();
      chk("wl_valid",   32'(bus.out_valid),    32'd1);
      chk("wl_data",    bus.out_data,          32'h1234_5678);
      chk("wl_rd",      32'(bus.out_rd),       32'd7);
      chk("wl_ready2",  32'(bus.in_ready),     32'd1);
      chk("wl_memen2",  32'(bus.mem_enable),   32'd0);

      // byte loads: signed, unsigned, other lanes
      issue_load(32'h8002_0011, 5'd8, 1'b1, 1'b0);
      bus.mem_rdata = 32'h00F0_0000;
      cyc(); idle_inputs();
      chk("bl_byteonly", 32'(bus.mem_byte_only), 32'd1);
      cyc();
      chk("bl_signed",   bus.out_data, 32'hFFFF_FFF0);
      issue_load(32'h8002_0011, 5'd8, 1'b1, 1'b1);
      cyc(); idle_inputs(); cyc();
      chk("bl_unsigned", bus.out_data, 32'h0000_00F0);
      issue_load(32'h8002_0013, 5'd8, 1'b1, 1'b0);
      bus.mem_rdata = 32'h0000_0080;
      cyc(); idle_inputs(); cyc();
      chk("bl_lane3",    bus.out_data, 32'hFFFF_FF80);
      issue_load(32'h8002_0010, 5'd8, 1'b1, 1'b0);
      bus.mem_rdata = 32'h7F11_2233;
      cyc(); idle_inputs(); cyc();
      chk("bl_lane0",    bus.out_data, 32'h0000_007F);

      // byte store with three busy cycles
      idle_inputs();
      bus.in_valid = 1'b1; bus.in_store = 1'b1; bus.in_byte = 1'b1; bus.in_rwe = 1'b1;
      bus.in_rd = 5'd9; bus.in_alu_out = 32'h8002_0023; bus.in_store_data = 32'h0000_00AB;
      bus.mem_busy = 1'b1;
      cyc(); idle_inputs();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) bus.mem_busy = 1'b0;
         chk("bs_wdata",    bus.mem_wdata,               32'hABAB_ABAB);
         chk("bs_wren",     32'(bus.mem_wren),           32'd1);
         chk("bs_byteonly", 32'(bus.mem_byte_only),      32'd1);
         chk("bs_ready",    32'(bus.in_ready),           32'd0);
         cyc();
      end
      chk("bs_valid",   32'(bus.out_valid),  32'd1);
      chk("bs_rwe",     32'(bus.out_rwe),    32'd0);
      chk("bs_memen",   32'(bus.mem_enable), 32'd0);

      // load and store together behave as a word store
      idle_inputs();
      bus.in_valid = 1'b1; bus.in_load = 1'b1; bus.in_store = 1'b1; bus.in_rwe = 1'b1;
      bus.in_alu_out = 32'h8002_0020; bus.in_store_data = 32'hDEAD_BEEF;
      cyc(); idle_inputs();
      chk("ls_wren",    32'(bus.mem_wren),  32'd1);
      chk("ls_wdata",   bus.mem_wdata,      32'hDEAD_BEEF);
      cyc();
      chk("ls_rwe",     32'(bus.out_rwe),   32'd0);

      // timeout: busy never drops
      issue_load(32'h8002_0030, 5'd4, 1'b0, 1'b0);
      bus.mem_busy = 1'b1;
      cyc(); idle_inputs();
      for (int i = 0; i <= int'(MAX_WAIT); i++) begin
         chk("to_waiting", 32'({bus.mem_enable, bus.err_timeout}), 32'd2);
         cyc();
      end
      bus.mem_busy = 1'b0;
      chk("to_err",     32'(bus.err_timeout), 32'd1);
      chk("to_valid",   32'(bus.out_valid),   32'd1);
      chk("to_rwe",     32'(bus.out_rwe),     32'd0);
      chk("to_ready",   32'(bus.in_ready),    32'd1);

      // misaligned word load
      issue_load(32'h8002_0002, 5'd6, 1'b0, 1'b0);
      cyc(); idle_inputs();
      chk("ma_err",     32'(bus.err_misalign), 32'd1);
      chk("ma_valid",   32'(bus.out_valid),    32'd1);
      chk("ma_rwe",     32'(bus.out_rwe),      32'd0);
      chk("ma_memen",   32'(bus.mem_enable),   32'd0);
      cyc();
      chk("ma_memen2",  32'(bus.mem_enable),   32'd0);
      chk("ma_sticky",  32'({bus.err_misalign, bus.err_timeout}), 32'd3);

      // asynchronous reset in the middle of an access
      issue_load(32'h8002_0040, 5'd2, 1'b0, 1'b0);
      bus.mem_busy = 1'b1;
      cyc(); idle_inputs();
      chk("ar_memen",   32'(bus.mem_enable), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_memen0",  32'(bus.mem_enable), 32'd0);
      chk("ar_wren0",   32'(bus.mem_wren),   32'd0);
      chk("ar_valid0",  32'(bus.out_valid),  32'd0);
      chk("ar_ready",   32'(bus.in_ready),   32'd1);
      chk("ar_data0",   bus.out_data,        32'h0);
      chk("ar_errs0",   32'({bus.err_misalign, bus.err_timeout}), 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      bus.mem_busy = 1'b0;
      bus.in_valid = 1'b1; bus.in_alu_out = 32'h0000_0055; bus.in_rd = 5'd3; bus.in_rwe = 1'b1;
      cyc(); idle_inputs();
      chk("ar_alu_valid", 32'(bus.out_valid), 32'd1);
      chk("ar_alu_data",  bus.out_data,       32'h0000_0055);
      cyc();
      chk("ar_noreplay",  32'({bus.out_valid, bus.mem_enable}), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
